// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with configurable width and terminal count,
// synchronous clear/load, wrap-or-saturate at the limits and optional
// rising-edge qualification of the inc/dec strobes. All outputs are registered.
module updown_counter_param #(
   parameter int               WIDTH     = 16,
   parameter logic [WIDTH-1:0] MAX_VALUE = {WIDTH{1'b1}},
   parameter bit               SATURATE  = 1'b0,
   parameter bit               EDGE_MODE = 1'b1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             dec,
   input  logic             clear,
   input  logic             load,
   input  logic [WIDTH-1:0] load_value,
   output logic [WIDTH-1:0] count,
   output logic             at_max,
   output logic             at_min,
   output logic             wrap_up,
   output logic             wrap_dn
);

   logic             inc_q;
   logic             dec_q;
   logic             up_req;
   logic             dn_req;
   logic [WIDTH-1:0] next_count;
   logic             next_wrap_up;
   logic             next_wrap_dn;

   // A held strobe counts once in edge mode; the history registers start at
   // 0 so a strobe already high when reset releases counts as a rising edge.
   assign up_req = EDGE_MODE ? (inc & ~inc_q) : inc;
   assign dn_req = EDGE_MODE ? (dec & ~dec_q) : dec;

   // Strobe history for edge detection, updated every cycle whatever else happens.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         inc_q <= 1'b0;
         dec_q <= 1'b0;
      end else begin
         inc_q <= inc;
         dec_q <= dec;
      end
   end

   // Next count and wrap pulses: clear, then load, then opposing requests cancel,
   // then a single up or down step.
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // leaves it unassigned and no latch is inferred.
      next_count   = count;
      next_wrap_up = 1'b0;
      next_wrap_dn = 1'b0;
      if (clear) begin
         next_count = '0;
      end else if (load) begin
         next_count = (load_value > MAX_VALUE) ? MAX_VALUE : load_value;
      end else if (up_req && !dn_req) begin
         if (count == MAX_VALUE) begin
            next_wrap_up = 1'b1;
            if (!SATURATE) next_count = '0;
         end else begin
            next_count = count + WIDTH'(1);
         end
      end else if (dn_req && !up_req) begin
         if (count == '0) begin
            next_wrap_dn = 1'b1;
            if (!SATURATE) next_count = MAX_VALUE;
         end else begin
            next_count = count - WIDTH'(1);
         end
      end
   end

   // Count, limit flags and wrap pulses registered together; flags come from
   // next_count so they always agree with the count they describe.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count   <= '0;
         at_max  <= 1'b0;
         at_min  <= 1'b1;
         wrap_up <= 1'b0;
         wrap_dn <= 1'b0;
      end else begin
         count   <= next_count;
         at_max  <= (next_count == MAX_VALUE);
         at_min  <= (next_count == '0);
         wrap_up <= next_wrap_up;
         wrap_dn <= next_wrap_dn;
      end
   end

endmodule

// File: tb/tb_updown_counter_param.sv
// Self-checking bench for updown_counter_param. Four instances share one set
// of stimulus: default (16-bit, edge, wrap), level mode, 4-bit mod-10 wrap and
// 4-bit mod-10 saturate. Each instance has its own arithmetic reference model.
module tb_updown_counter_param;

   logic        clk = 1'b0;
   logic        reset;
   logic        inc, dec, clear, load;
   logic [15:0] lv;

   logic [15:0] c0, c1;
   logic [3:0]  c2, c3;
   logic [3:0]  amx, amn, wu, wd;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   updown_counter_param dut0 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_value(lv), .count(c0), .at_max(amx[0]), .at_min(amn[0]),
      .wrap_up(wu[0]), .wrap_dn(wd[0]));

   updown_counter_param #(.EDGE_MODE(1'b0)) dut1 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_value(lv), .count(c1), .at_max(amx[1]), .at_min(amn[1]),
      .wrap_up(wu[1]), .wrap_dn(wd[1]));

   updown_counter_param #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b0)) dut2 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_value(lv[3:0]), .count(c2), .at_max(amx[2]), .at_min(amn[2]),
      .wrap_up(wu[2]), .wrap_dn(wd[2]));

   updown_counter_param #(.WIDTH(4), .MAX_VALUE(4'd9), .SATURATE(1'b1)) dut3 (
      .clk(clk), .reset(reset), .inc(inc), .dec(dec), .clear(clear), .load(load),
      .load_value(lv[3:0]), .count(c3), .at_max(amx[3]), .at_min(amn[3]),
      .wrap_up(wu[3]), .wrap_dn(wd[3]));

   // Reference model configuration and state, one entry per instance.
   longint mmax  [4] = '{65535, 65535, 9, 9};
   longint mmask [4] = '{65535, 65535, 15, 15};
   bit     msat  [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
   bit     medge [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
   longint mc    [4];
   bit     mwu   [4], mwd [4], mpi [4], mpd [4];
   int     pulses_up [4], pulses_dn [4];

   task automatic check(input string tag, input longint obs, input longint exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic longint obs_count(input int i);
      case (i)
         0:       return longint'(c0);
         1:       return longint'(c1);
         2:       return longint'(c2);
         default: return longint'(c3);
      endcase
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 4; i++) begin
         mc[i] = 0; mwu[i] = 1'b0; mwd[i] = 1'b0; mpi[i] = 1'b0; mpd[i] = 1'b0;
      end
   endtask

   task automatic clear_pulse_counts();
      for (int i = 0; i < 4; i++) begin
         pulses_up[i] = 0; pulses_dn[i] = 0;
      end
   endtask

   // One clock edge of the reference model, using the inputs applied at that edge.
   task automatic model_step();
      bit     up, dn;
      longint v;
      for (int i = 0; i < 4; i++) begin
         up = medge[i] ? (inc && !mpi[i]) : inc;
         dn = medge[i] ? (dec && !mpd[i]) : dec;
         mpi[i] = inc;
         mpd[i] = dec;
         mwu[i] = 1'b0;
         mwd[i] = 1'b0;
         if (clear) begin
            mc[i] = 0;
         end else if (load) begin
            v = longint'(lv) & mmask[i];
            mc[i] = (v > mmax[i]) ? mmax[i] : v;
         end else if (up && !dn) begin
            mwu[i] = (mc[i] == mmax[i]);
            mc[i]  = msat[i] ? ((mc[i] + 1 > mmax[i]) ? mmax[i] : mc[i] + 1)
                             : (mc[i] + 1) % (mmax[i] + 1);
         end else if (dn && !up) begin
            mwd[i] = (mc[i] == 0);
            mc[i]  = msat[i] ? ((mc[i] == 0) ? 0 : mc[i] - 1)
                             : (mc[i] + mmax[i]) % (mmax[i] + 1);
         end
      end
   endtask

   task automatic compare_all(input string tag);
      longint exp_flags;
      for (int i = 0; i < 4; i++) begin
         check($sformatf("%s.count%0d", tag, i), obs_count(i), mc[i]);
         exp_flags = {60'd0, mc[i] == mmax[i], mc[i] == 0, mwu[i], mwd[i]};
         check($sformatf("%s.flags%0d", tag, i),
               longint'({amx[i], amn[i], wu[i], wd[i]}), exp_flags);
      end
   endtask

   // Apply inputs, take one edge, sample 1 ns later, advance model and compare.
   task automatic drive(input bit i_inc, input bit i_dec, input bit i_clr,
                        input bit i_ld, input logic [15:0] i_lv, input string tag);
      inc = i_inc; dec = i_dec; clear = i_clr; load = i_ld; lv = i_lv;
      @(posedge clk);
      #1;
      model_step();
      for (int i = 0; i < 4; i++) begin
         pulses_up[i] += int'(wu[i]);
         pulses_dn[i] += int'(wd[i]);
      end
      compare_all(tag);
   endtask

   initial begin
      inc = 1'b0; dec = 1'b0; clear = 1'b0; load = 1'b0; lv = '0;
      reset = 1'b1;
      model_reset();
      clear_pulse_counts();
      #12 reset = 1'b0;
      compare_all("reset");

      // Reset mid-count: asynchronous, no clock edge needed.
      drive(0, 0, 0, 1, 16'd37, "ld37");
      drive(0, 0, 0, 0, 16'd0, "idle");
      check("count_37", longint'(c0), 37);
      #3 reset = 1'b1;
      #1;
      check("async_rst_count", longint'(c0), 0);
      check("async_rst_at_min", longint'(amn[0]), 1);
      model_reset();
      compare_all("async_rst");
      inc = 1'b1;
      #2 reset = 1'b0;
      drive(1, 0, 0, 0, 16'd0, "post_rst_inc");
      check("post_rst_count", longint'(c0), 1);
      drive(0, 0, 0, 0, 16'd0, "idle");

      // Edge vs level qualification: 10 bursts of inc high 4 cycles, low 4.
      drive(0, 0, 1, 0, 16'd0, "clr");
      for (int r = 0; r < 10; r++) begin
         for (int k = 0; k < 4; k++) drive(1, 0, 0, 0, 16'd0, "burst_hi");
         for (int k = 0; k < 4; k++) drive(0, 0, 0, 0, 16'd0, "burst_lo");
      end
      check("edge_mode_count", longint'(c0), 10);
      check("level_mode_count", longint'(c1), 40);

      // Wrap at MAX_VALUE=9.
      drive(0, 0, 1, 0, 16'd0, "clr");
      clear_pulse_counts();
      for (int k = 0; k < 10; k++) begin
         drive(1, 0, 0, 0, 16'd0, "wrap_up");
         drive(0, 0, 0, 0, 16'd0, "wrap_lo");
      end
      check("wrap_count", longint'(c2), 0);
      check("wrap_up_pulses", pulses_up[2], 1);
      clear_pulse_counts();
      drive(0, 1, 0, 0, 16'd0, "wrap_dn");
      check("wrap_dn_flag", longint'(wd[2]), 1);
      drive(0, 0, 0, 0, 16'd0, "wrap_lo");
      check("wrap_dn_count", longint'(c2), 9);
      check("wrap_dn_pulses", pulses_dn[2], 1);

      // Saturate at 9 and at 0.
      drive(0, 0, 1, 0, 16'd0, "clr");
      clear_pulse_counts();
      for (int k = 0; k < 12; k++) begin
         drive(1, 0, 0, 0, 16'd0, "sat_up");
         drive(0, 0, 0, 0, 16'd0, "sat_lo");
      end
      check("sat_max_count", longint'(c3), 9);
      check("sat_at_max", longint'(amx[3]), 1);
      check("sat_up_pulses", pulses_up[3], 3);
      for (int k = 0; k < 12; k++) begin
         drive(0, 1, 0, 0, 16'd0, "sat_dn");
         drive(0, 0, 0, 0, 16'd0, "sat_lo");
      end
      check("sat_min_count", longint'(c3), 0);
      check("sat_at_min", longint'(amn[3]), 1);

      // Priority cases.
      drive(1, 0, 1, 1, 16'd15, "clr_ld_inc");
      check("prio_clear_c0", longint'(c0), 0);
      check("prio_clear_c2", longint'(c2), 0);
      drive(0, 0, 0, 1, 16'd15, "ld15");
      check("load_clamp_c2", longint'(c2), 9);
      check("load_clamp_c3", longint'(c3), 9);
      check("load_c0", longint'(c0), 15);
      drive(1, 1, 0, 0, 16'd0, "inc_dec");
      check("inc_dec_c2", longint'(c2), 9);
      check("inc_dec_pulses", longint'({wu[2], wd[2]}), 0);
      check("inc_dec_c0", longint'(c0), 15);
      drive(0, 0, 0, 0, 16'd0, "idle");

      // Top of the default 16-bit range.
      drive(0, 0, 0, 1, 16'hFFFD, "ld_top");
      drive(0, 0, 0, 0, 16'd0, "idle");
      for (int k = 0; k < 2; k++) begin
         drive(1, 0, 0, 0, 16'd0, "top_up");
         drive(0, 0, 0, 0, 16'd0, "top_lo");
      end
      check("full_count", longint'(c0), 65535);
      check("full_at_max", longint'(amx[0]), 1);
      drive(1, 0, 0, 0, 16'd0, "top_wrap");
      check("full_wrap_count", longint'(c0), 0);
      check("full_wrap_up", longint'(wu[0]), 1);
      check("full_wrap_at_min", longint'(amn[0]), 1);
      drive(0, 0, 0, 0, 16'd0, "idle");

      // Randomised traffic against the models.
      for (int k = 0; k < 600; k++) begin
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ($urandom_range(0, 31) == 0), ($urandom_range(0, 15) == 0),
               16'($urandom), "rand");
      end

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
